breakout_pixel_gen: RTL

- Sits directly downstream of the VGA sync generator. Consumes its `hcount`, `vcount` and `inDispArea` outputs.
- Holds the breakout ball and paddle game state. Positions update once per frame, during vertical blank.
- Produces registered 1-bit-per-channel RGB for the DAC.
- Ball motion is driven by a serve/play/miss state machine; the paddle is driven by two buttons.

---
 rtl/breakout_pixel_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/breakout_pixel_gen.sv
// Breakout ball/paddle game state and 1-bit RGB renderer, downstream of the VGA sync generator.
// Optional MISS_FLASH_EN: red background flash for 8 frames after a miss.
module breakout_pixel_gen #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PADDLE_W     = 64,
    parameter int unsigned PADDLE_H     = 8,
    parameter int unsigned PADDLE_Y     = 456,
    parameter int unsigned BALL_STEP    = 2,
    parameter int unsigned PADDLE_STEP  = 4,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       inDispArea,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       miss
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]  BALL_X0      = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  BALL_Y0      = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  PADDLE_X0    = 10'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [9:0]  BALL_X_MAX10 = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  PAD_X_MAX10  = 10'(H_ACTIVE - PADDLE_W);
    localparam logic [9:0]  BALL_HIT_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] X_MAX        = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX        = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] P_MAX        = 11'(H_ACTIVE - PADDLE_W);
    localparam logic [10:0] B_SIZE       = 11'(BALL_SIZE);
    localparam logic [10:0] B_STEP       = 11'(BALL_STEP);
    localparam logic [10:0] P_STEP       = 11'(PADDLE_STEP);
    localparam logic [10:0] P_W          = 11'(PADDLE_W);
    localparam logic [10:0] P_H          = 11'(PADDLE_H);
    localparam logic [10:0] P_Y          = 11'(PADDLE_Y);

    typedef enum logic [1:0] {StServe, StPlay, StMiss} state_e;

    state_e             state_q, state_d;
    logic [9:0]         ball_x_q, ball_x_d;
    logic [9:0]         ball_y_q, ball_y_d;
    logic [9:0]         paddle_x_q, paddle_x_d;
    logic               dx_q, dx_d;  // 1: moving right
    logic               dy_q, dy_d;  // 1: moving down
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic               miss_d;
    logic               red_d, green_d, blue_d;
    logic               bg_red;

    logic        frame_tick;
    logic [10:0] bx, by, px, hc, vc;
    logic        paddle_hit, in_ball, in_paddle;

    assign frame_tick = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
    assign bx = {1'b0, ball_x_q};
    assign by = {1'b0, ball_y_q};
    assign px = {1'b0, paddle_x_q};
    assign hc = {1'b0, hcount};
    assign vc = {1'b0, vcount};

    assign paddle_hit = (by + B_SIZE <= P_Y) && (by + B_SIZE + B_STEP >= P_Y) &&
                        (bx + B_SIZE > px) && (bx < px + P_W);

`ifdef MISS_FLASH_EN
    logic [3:0] flash_q, flash_d;
    assign bg_red = (flash_q != 4'd0);
`else
    assign bg_red = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        paddle_x_d  = paddle_x_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_cnt_d = serve_cnt_q;
        miss_d      = 1'b0;
`ifdef MISS_FLASH_EN
        flash_d     = flash_q;
`endif
        if (frame_tick) begin
            if (btn_left && !btn_right) begin
                paddle_x_d = (px >= P_STEP) ? 10'(px - P_STEP) : 10'd0;
            end else if (btn_right && !btn_left) begin
                paddle_x_d = (px + P_STEP >= P_MAX) ? PAD_X_MAX10 : 10'(px + P_STEP);
            end
`ifdef MISS_FLASH_EN
            if (flash_q != 4'd0) flash_d = flash_q - 4'd1;
`endif
            unique case (state_q)
                StServe: begin
                    if (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        serve_cnt_d = '0;
                        dx_d        = 1'b1;
                        dy_d        = 1'b0;
                        state_d     = StPlay;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
                StPlay: begin
                    if (dx_q) begin
                        if (bx + B_STEP >= X_MAX) begin
                            ball_x_d = BALL_X_MAX10;
                            dx_d     = 1'b0;
                        end else begin
                            ball_x_d = 10'(bx + B_STEP);
                        end
                    end else if (bx <= B_STEP) begin
                        ball_x_d = 10'd0;
                        dx_d     = 1'b1;
                    end else begin
                        ball_x_d = 10'(bx - B_STEP);
                    end

                    if (!dy_q) begin
                        if (by <= B_STEP) begin
                            ball_y_d = 10'd0;
                            dy_d     = 1'b1;
                        end else begin
                            ball_y_d = 10'(by - B_STEP);
                        end
                    end else if (paddle_hit) begin
                        ball_y_d = BALL_HIT_Y;
                        dy_d     = 1'b0;
                    end else if (by + B_STEP >= Y_MAX) begin
                        state_d = StMiss;
                        miss_d  = 1'b1;
`ifdef MISS_FLASH_EN
                        flash_d = 4'd8;
`endif
                    end else begin
                        ball_y_d = 10'(by + B_STEP);
                    end
                end
                StMiss: begin
                    ball_x_d    = BALL_X0;
                    ball_y_d    = BALL_Y0;
                    serve_cnt_d = '0;
                    state_d     = StServe;
                end
                default: state_d = StServe;
            endcase
        end
    end

    assign in_ball   = (hc >= bx) && (hc < bx + B_SIZE) && (vc >= by) && (vc < by + B_SIZE) &&
                       (state_q != StMiss);
    assign in_paddle = (hc >= px) && (hc < px + P_W) && (vc >= P_Y) && (vc < P_Y + P_H);

    always_comb begin
        red_d   = 1'b0;
        green_d = 1'b0;
        blue_d  = 1'b0;
        if (inDispArea) begin
            if (in_ball) begin
                red_d   = 1'b1;
                green_d = 1'b1;
                blue_d  = 1'b1;
            end else if (in_paddle) begin
                blue_d  = 1'b1;
            end else begin
                red_d   = bg_red;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StServe;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            paddle_x_q  <= PADDLE_X0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b0;
            serve_cnt_q <= '0;
            miss        <= 1'b0;
            red         <= 1'b0;
            green       <= 1'b0;
            blue        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            paddle_x_q  <= paddle_x_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_cnt_q <= serve_cnt_d;
            miss        <= miss_d;
            red         <= red_d;
            green       <= green_d;
            blue        <= blue_d;
        end
    end

`ifdef MISS_FLASH_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) flash_q <= 4'd0;
        else         flash_q <= flash_d;
    end
`endif

endmodule
